snowflake_system_regs: RTL
==========================

Name: snowflake_system_regs

Overview:
Memory-mapped system peripheral block for the snowflake platform. It sits directly downstream of the system bus's sys_* port and decodes the 0x1000-0x10FF window. It provides a 64-bit machine timer with a compare interrupt, a UART transmitter with a TX FIFO, and an LED register. Reads have registered data, valid in the cycle after the request, which is the cycle in which the bus raises its ack.

Parameters:
FIFO_DEPTH, 8, UART TX FIFO entries; power of 2, range 2..64.
DEFAULT_DIV, 16'd867, reset value of UART_DIV; bit period = UART_DIV+1 clk cycles.
MTIME_PRESCALE, 1, clk cycles per mtime increment; must be >= 1.

Ports:
clk  input  1  system clock
rstz  input  1  asynchronous active-low reset
sys_addr  input  32  byte address; only [7:2] decoded
sys_rd_data  output  32  registered read data
sys_wr_data  input  32  write data; full-word writes only
sys_en  input  1  access strobe, one cycle per access
sys_wr_en  input  1  1 = write, 0 = read; qualified by sys_en
timer_irq  output  1  registered, high while mtime >= mtimecmp
uart_tx  output  1  serial TX line, idle high
leds  output  8  LED register bits [7:0]

Behaviour:
- Reset is asynchronous and active-low. All state clears immediately when rstz falls, including mid-frame: the frame is aborted and the FIFO is emptied.
- Reset values: sys_rd_data=0, timer_irq=0, uart_tx=1, leds=0, mtime=0, mtimecmp=all ones, UART_DIV=DEFAULT_DIV, overflow=0, prescale counter=0.
- Register map (offset = sys_addr[7:0]):
  - 0x00 MTIME_LO: rw.
  - 0x04 MTIME_HI: rw.
  - 0x08 MTIMECMP_LO: rw.
  - 0x0C MTIMECMP_HI: rw.
  - 0x10 UART_TXDATA: write pushes wr_data[7:0]; reads return 0.
  - 0x14 UART_STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[10:4] FIFO count. Writing 1 to bit3 clears overflow.
  - 0x18 UART_DIV: [15:0] rw, upper bits read 0.
  - 0x1C LEDS: [7:0] rw.
  - All other offsets: writes ignored, reads return 0.
- Reads: when sys_en & ~sys_wr_en, sys_rd_data <= selected register at the next edge. sys_rd_data holds its value otherwise; writes do not change it.
- Writes take effect at the edge ending the sys_en cycle. There is no error response.
- mtime:
  - A prescale counter counts 0..MTIME_PRESCALE-1. mtime += 1 (64-bit, wraps from all ones to 0) on each cycle where the counter is at its terminal value.
  - A write to MTIME_LO or MTIME_HI replaces that half, and that cycle's increment is suppressed for the whole 64-bit value (no carry into a freshly written half).
- timer_irq <= (mtime >= mtimecmp), evaluated on the pre-edge values, so it lags one cycle behind the counter and register writes. Writing mtimecmp above mtime drops timer_irq two edges after the write.
- TX FIFO:
  - Circular buffer with read/write pointers one bit wider than the index; count = wptr - rptr.
  - Push when UART_TXDATA is written and the FIFO is not full.
  - Push while full: data is dropped, overflow <= 1, pointers unchanged.
  - A simultaneous push and pop in the same cycle is legal in every fill state and leaves count unchanged. When the FIFO is full, a pop in the same cycle does not free space for that cycle's push: the push is dropped and overflow is set.
- UART FSM (IDLE, START, DATA, STOP):
  - Bit-timer counts 0..UART_DIV; the bit ends when the timer reaches UART_DIV.
  - IDLE: uart_tx=1. If the FIFO is not empty, pop the head into the shift register, go to START, and clear the timer.
  - START: uart_tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] (LSB first). At bit end, shift right and increment the index; after 8 bits go to STOP.
  - STOP: uart_tx=1 for one bit period, then return to IDLE.
  - If the FIFO is not empty at stop end, the next START begins on the following cycle (one idle cycle between frames).
  - UART_DIV is sampled continuously. Changing it mid-frame affects the remaining bits of that frame; software avoids doing so.
- uart_tx is registered. Frame length = 10*(UART_DIV+1) cycles.

Test Plan:
- Reset values: assert rstz=0 mid-run, then release. Read UART_STATUS -> 0x00000002; read MTIMECMP_HI -> 0xFFFFFFFF; uart_tx=1, leds=0, timer_irq=0.
- Read latency: write LEDS=0xA5, then read 0x1C. sys_rd_data=0x000000A5 on the cycle after the read strobe; leds=0xA5. Read 0x40 -> sys_rd_data=0.
- Timer (MTIME_PRESCALE=1): write MTIMECMP_HI=0, MTIMECMP_LO=20, MTIME_LO=0. timer_irq rises exactly 21 cycles after the MTIME_LO write edge. Write MTIMECMP_HI=1 -> timer_irq low two edges later. Write MTIME_LO=0xFFFFFFFF with MTIME_HI=0 -> HI reads 1 after the carry.
- UART frame: set UART_DIV=3 and write TXDATA=0x55. uart_tx shows 0,1,0,1,0,1,0,1,0,1, each bit held exactly 4 cycles (40 cycles total), and busy=1 throughout.
- FIFO full/overflow (FIFO_DEPTH=8, UART_DIV=3): write 10 bytes back-to-back starting from idle. The first byte pops immediately, the next 8 fill the FIFO, and the 10th is dropped. STATUS then reads full=1, overflow=1, count=8. Write STATUS=0x8 -> overflow=0. Transmitted sequence = the first 9 bytes in order.
- Push/pop collision: with the FIFO holding 1 byte, write TXDATA in the exact cycle the FSM pops in IDLE. Count stays 1, no overflow, and both bytes are transmitted in order.

Source files
------------

// File: rtl/snowflake_system_regs.sv
// snowflake_system_regs: machine timer, UART transmitter with TX FIFO and LED register on the sys bus
module snowflake_system_regs #(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] DEFAULT_DIV    = 16'd867,
    parameter int          MTIME_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] sys_addr,
    output logic [31:0] sys_rd_data,
    input  logic [31:0] sys_wr_data,
    input  logic        sys_en,
    input  logic        sys_wr_en,
    output logic        timer_irq,
    output logic        uart_tx,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = MTIME_PRESCALE > 1 ? $clog2(MTIME_PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [63:0]   mtime, mtimecmp;
    logic [PW-1:0] pcnt;
    logic [15:0]   div, timer;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, count;
    logic [7:0]    shift;
    logic [2:0]    idx;
    logic [5:0]    off;
    logic [31:0]   rsel;
    logic          overflow, wr, rd, tick, full, empty, push_req, pop, bit_end;
    logic          unused_addr;

    assign off         = sys_addr[7:2];
    assign unused_addr = ^{sys_addr[31:8], sys_addr[1:0]};
    assign wr          = sys_en & sys_wr_en;
    assign rd          = sys_en & ~sys_wr_en;
    assign tick        = pcnt == PW'(MTIME_PRESCALE - 1);
    assign count       = wptr - rptr;
    assign full        = count[AW];
    assign empty       = wptr == rptr;
    assign push_req    = wr && off == 6'h4;
    assign pop         = state == IDLE && !empty;
    assign bit_end     = timer == div;

    // read-data select for the decoded word offset
    always_comb begin
        rsel = '0;
        case (off)
            6'h0:    rsel = mtime[31:0];
            6'h1:    rsel = mtime[63:32];
            6'h2:    rsel = mtimecmp[31:0];
            6'h3:    rsel = mtimecmp[63:32];
            6'h5:    rsel = {21'b0, 7'(count), overflow, state != IDLE, empty, full};
            6'h6:    rsel = {16'b0, div};
            6'h7:    rsel = {24'b0, leds};
            default: rsel = '0;
        endcase
    end

    // bus-visible registers, registered read data and the compare interrupt
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sys_rd_data <= '0;
            leds        <= '0;
            div         <= DEFAULT_DIV;
            mtimecmp    <= '1;
            overflow    <= 1'b0;
            timer_irq   <= 1'b0;
        end else begin
            if (rd) sys_rd_data <= rsel;
            timer_irq <= mtime >= mtimecmp;
            if (wr && off == 6'h2) mtimecmp[31:0] <= sys_wr_data;
            if (wr && off == 6'h3) mtimecmp[63:32] <= sys_wr_data;
            if (wr && off == 6'h6) div <= sys_wr_data[15:0];
            if (wr && off == 6'h7) leds <= sys_wr_data[7:0];
            if (push_req && full) overflow <= 1'b1;
            else if (wr && off == 6'h5 && sys_wr_data[3]) overflow <= 1'b0;
        end
    end

    // prescaled 64-bit mtime; a half write suppresses that cycle's increment
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            pcnt  <= '0;
            mtime <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            if (wr && off == 6'h0) mtime[31:0] <= sys_wr_data;
            else if (wr && off == 6'h1) mtime[63:32] <= sys_wr_data;
            else if (tick) mtime <= mtime + 64'd1;
        end
    end

    // FIFO write pointer; a full FIFO drops the push even if the FSM pops this cycle
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) wptr <= '0;
        else if (push_req && !full) wptr <= wptr + (AW+1)'(1);
    end

    // FIFO storage needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_req && !full) mem[wptr[AW-1:0]] <= sys_wr_data[7:0];
    end

    // UART transmit FSM, owns the read pointer and the registered TX line
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state   <= IDLE;
            timer   <= '0;
            idx     <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
            rptr    <= '0;
        end else begin
            timer <= bit_end ? '0 : timer + 16'd1;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    timer   <= '0;
                    if (pop) begin
                        shift   <= mem[rptr[AW-1:0]];
                        rptr    <= rptr + (AW+1)'(1);
                        state   <= START;
                        uart_tx <= 1'b0;
                    end
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    idx     <= '0;
                    uart_tx <= shift[0];
                end
                DATA: if (bit_end) begin
                    shift   <= shift >> 1;
                    idx     <= idx + 3'd1;
                    uart_tx <= idx == 3'd7 ? 1'b1 : shift[1];
                    state   <= idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (bit_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
